// File: rtl/regbus_arbiter.sv
// Round-robin arbiter between the SPI register bridge (port A) and the Maple
// sequencer (port B) for the shared one-hot register bus.
module regbus_arbiter #(
    parameter int num_regs    = 128,
    parameter int wait_cycles = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_req,
    input  logic                a_wr,
    input  logic [6:0]          a_addr,
    input  logic [7:0]          a_wdata,
    output logic [7:0]          a_rdata,
    output logic                a_ack,
    output logic                a_err,
    input  logic                b_req,
    input  logic                b_wr,
    input  logic [6:0]          b_addr,
    input  logic [7:0]          b_wdata,
    output logic [7:0]          b_rdata,
    output logic                b_ack,
    output logic                b_err,
    output logic [num_regs-1:0] cs,
    output logic                we,
    output logic [7:0]          regdata_write,
    input  logic [7:0]          regdata_read,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [7:0] NUM_REGS = 8'(num_regs);
    localparam logic [3:0] WAIT_LD  = 4'(wait_cycles);

    state_t               state;
    logic                 last_grant;  // 0 = A, 1 = B
    logic                 gnt_port;
    logic                 gnt_wr;
    logic                 gnt_err;
    logic [3:0]           wait_cnt;

    logic                 pick_b;
    logic                 sel_wr;
    logic [6:0]           sel_addr;
    logic [7:0]           sel_wdata;
    logic                 sel_in_range;
    logic [num_regs-1:0]  cs_dec;

    // Handshake: a port raises req with stable wr/addr/wdata and holds it until
    // the cycle ack is high; req still high after that is a fresh request.
    always_comb begin
        pick_b       = b_req && (!a_req || !last_grant);
        sel_wr       = pick_b ? b_wr    : a_wr;
        sel_addr     = pick_b ? b_addr  : a_addr;
        sel_wdata    = pick_b ? b_wdata : a_wdata;
        sel_in_range = ({1'b0, sel_addr} < NUM_REGS);
        cs_dec       = '0;
        for (int i = 0; i < num_regs; i++) begin
            if (sel_addr == 7'(i)) cs_dec[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            gnt_port      <= 1'b0;
            gnt_wr        <= 1'b0;
            gnt_err       <= 1'b0;
            wait_cnt      <= '0;
            cs            <= '0;
            we            <= 1'b0;
            regdata_write <= '0;
            a_rdata       <= '0;
            b_rdata       <= '0;
            a_ack         <= 1'b0;
            b_ack         <= 1'b0;
            a_err         <= 1'b0;
            b_err         <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        gnt_port      <= pick_b;
                        gnt_wr        <= sel_wr;
                        gnt_err       <= !sel_in_range;
                        last_grant    <= pick_b;
                        wait_cnt      <= WAIT_LD;
                        cs            <= cs_dec;
                        we            <= sel_wr && sel_in_range;
                        regdata_write <= sel_wdata;
                        busy          <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        // Out-of-range reads float high, as an undriven bus would.
                        if (!gnt_wr) begin
                            if (gnt_port) b_rdata <= gnt_err ? 8'hFF : regdata_read;
                            else          a_rdata <= gnt_err ? 8'hFF : regdata_read;
                        end
                        if (gnt_port) begin
                            b_ack <= 1'b1;
                            b_err <= gnt_err;
                        end else begin
                            a_ack <= 1'b1;
                            a_err <= gnt_err;
                        end
                        cs            <= '0;
                        we            <= 1'b0;
                        regdata_write <= '0;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    a_err <= 1'b0;
                    b_err <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_arbiter.sv
// Bench for regbus_arbiter: d0 (128 regs, no wait), d1 (16 regs, 2 wait states),
// each with a small register file model behind the bus.
module tb_regbus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req[2], a_wr[2], b_req[2], b_wr[2];
    logic [6:0]  a_addr[2], b_addr[2];
    logic [7:0]  a_wdata[2], b_wdata[2];
    logic [7:0]  a_rdata[2], b_rdata[2];
    logic        a_ack[2], a_err[2], b_ack[2], b_err[2];
    logic        we[2], busy[2];
    logic [7:0]  regdata_write[2], regdata_read[2];
    logic [127:0] cs0;
    logic [15:0]  cs1;

    logic [7:0]  mem0[128];
    logic [7:0]  mem1[16];
    bit          mem_init_done = 0;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_rd[2][2];
    logic [7:0]  exp_q[$];
    int          n_ack;

    typedef struct {
        int         d;
        bit         port;
        bit         wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        bit         err;
    } vec_t;
    vec_t vecs[13];

    regbus_arbiter #(.num_regs(128), .wait_cycles(0)) d0 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req[0]), .a_wr(a_wr[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
        .a_rdata(a_rdata[0]), .a_ack(a_ack[0]), .a_err(a_err[0]),
        .b_req(b_req[0]), .b_wr(b_wr[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
        .b_rdata(b_rdata[0]), .b_ack(b_ack[0]), .b_err(b_err[0]),
        .cs(cs0), .we(we[0]), .regdata_write(regdata_write[0]),
        .regdata_read(regdata_read[0]), .busy(busy[0])
    );

    regbus_arbiter #(.num_regs(16), .wait_cycles(2)) d1 (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req[1]), .a_wr(a_wr[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
        .a_rdata(a_rdata[1]), .a_ack(a_ack[1]), .a_err(a_err[1]),
        .b_req(b_req[1]), .b_wr(b_wr[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
        .b_rdata(b_rdata[1]), .b_ack(b_ack[1]), .b_err(b_err[1]),
        .cs(cs1), .we(we[1]), .regdata_write(regdata_write[1]),
        .regdata_read(regdata_read[1]), .busy(busy[1])
    );

    // Clock and register file models
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 128; i++) mem0[i] <= 8'(i) ^ 8'h55;
            for (int i = 0; i < 16; i++)  mem1[i] <= 8'(i) ^ 8'h3F;
            mem_init_done <= 1;
        end else begin
            for (int i = 0; i < 128; i++) if (we[0] && cs0[i]) mem0[i] <= regdata_write[0];
            for (int i = 0; i < 16; i++)  if (we[1] && cs1[i]) mem1[i] <= regdata_write[1];
        end
    end

    always_comb begin
        regdata_read[0] = 8'h00;
        regdata_read[1] = 8'h00;
        for (int i = 0; i < 128; i++) if (cs0[i]) regdata_read[0] = mem0[i];
        for (int i = 0; i < 16; i++)  if (cs1[i]) regdata_read[1] = mem1[i];
    end

    function automatic logic [127:0] get_cs(input int d);
        return (d == 0) ? cs0 : {112'b0, cs1};
    endfunction

    function automatic logic port_ack(input int d, input bit p);
        return p ? b_ack[d] : a_ack[d];
    endfunction

    function automatic logic port_err(input int d, input bit p);
        return p ? b_err[d] : a_err[d];
    endfunction

    function automatic logic [7:0] port_rdata(input int d, input bit p);
        return p ? b_rdata[d] : a_rdata[d];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input bit p, input bit req, input bit wr,
                         input logic [6:0] addr, input logic [7:0] wd);
        if (!p) begin
            a_req[d] = req; a_wr[d] = wr; a_addr[d] = addr; a_wdata[d] = wd;
        end else begin
            b_req[d] = req; b_wr[d] = wr; b_addr[d] = addr; b_wdata[d] = wd;
        end
    endtask

    // Driver: one isolated access, checked cycle by cycle
    task automatic do_txn(input int k, input vec_t v);
        int           w;
        bit           in_r;
        logic [127:0] exp_cs;
        w      = (v.d == 0) ? 0 : 2;
        in_r   = (v.d == 0) ? 1'b1 : (v.addr < 7'd16);
        exp_cs = in_r ? (128'd1 << v.addr) : 128'd0;
        @(posedge clk); #1;
        drive(v.d, v.port, 1'b1, v.wr, v.addr, v.wdata);
        @(negedge clk);
        chk($sformatf("v%0d idle busy", k), busy[v.d], 0);
        for (int c = 0; c <= w; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d cs c%0d", k, c), get_cs(v.d), exp_cs);
            chk($sformatf("v%0d we c%0d", k, c), we[v.d], v.wr && in_r);
            chk($sformatf("v%0d wdata c%0d", k, c), regdata_write[v.d], v.wdata);
            chk($sformatf("v%0d early ack c%0d", k, c), port_ack(v.d, v.port), 0);
            chk($sformatf("v%0d busy c%0d", k, c), busy[v.d], 1);
        end
        @(negedge clk);
        if (!v.wr) exp_rd[v.d][v.port] = v.rd;
        chk($sformatf("v%0d ack", k), port_ack(v.d, v.port), 1);
        chk($sformatf("v%0d err", k), port_err(v.d, v.port), v.err);
        chk($sformatf("v%0d other ack", k), port_ack(v.d, !v.port), 0);
        chk($sformatf("v%0d done cs", k), get_cs(v.d), 0);
        chk($sformatf("v%0d done we", k), we[v.d], 0);
        chk($sformatf("v%0d done wdata", k), regdata_write[v.d], 0);
        chk($sformatf("v%0d rdata", k), port_rdata(v.d, v.port), exp_rd[v.d][v.port]);
        chk($sformatf("v%0d other rdata", k), port_rdata(v.d, !v.port), exp_rd[v.d][!v.port]);
        @(posedge clk); #1;
        drive(v.d, v.port, 1'b0, v.wr, v.addr, v.wdata);
        @(negedge clk);
        chk($sformatf("v%0d post busy", k), busy[v.d], 0);
        chk($sformatf("v%0d post ack", k), port_ack(v.d, v.port), 0);
    endtask

    // Scoreboard: expected {port, cycle} of each ack, in order
    task automatic note_ack(input string tag, input bit p, input int c, input logic [7:0] rdv);
        logic [7:0] e;
        n_ack++;
        if (exp_q.size() == 0) begin
            chk({tag, " extra ack"}, {p, 7'(c)}, 8'h00);
        end else begin
            e = exp_q.pop_front();
            chk({tag, " ack order"}, {p, 7'(c)}, e);
            chk({tag, " ack rdata"}, port_rdata(0, p), rdv);
        end
    endtask

    initial begin
        int ack_seen;
        vecs[0]  = '{0, 1'b0, 1'b1, 7'h12, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{0, 1'b1, 1'b1, 7'h05, 8'h5A, 8'h00, 1'b0};
        vecs[2]  = '{0, 1'b0, 1'b0, 7'h05, 8'h00, 8'h5A, 1'b0};
        vecs[3]  = '{0, 1'b1, 1'b0, 7'h12, 8'h00, 8'hA5, 1'b0};
        vecs[4]  = '{0, 1'b0, 1'b1, 7'h7F, 8'hC3, 8'h00, 1'b0};
        vecs[5]  = '{0, 1'b1, 1'b0, 7'h7F, 8'h00, 8'hC3, 1'b0};
        vecs[6]  = '{0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h55, 1'b0};
        vecs[7]  = '{1, 1'b1, 1'b0, 7'h03, 8'h00, 8'h3C, 1'b0};
        vecs[8]  = '{1, 1'b0, 1'b0, 7'd20, 8'h00, 8'hFF, 1'b1};
        vecs[9]  = '{1, 1'b0, 1'b1, 7'd20, 8'h77, 8'h00, 1'b1};
        vecs[10] = '{1, 1'b0, 1'b0, 7'h0F, 8'h00, 8'h30, 1'b0};
        vecs[11] = '{1, 1'b1, 1'b1, 7'h0F, 8'h99, 8'h00, 1'b0};
        vecs[12] = '{1, 1'b0, 1'b0, 7'h0F, 8'h00, 8'h99, 1'b0};

        // Reset block
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive(d, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
            drive(d, 1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
            exp_rd[d][0] = 8'h00;
            exp_rd[d][1] = 8'h00;
        end
        repeat (3) @(negedge clk);
        chk("reset cs0", cs0, 0);
        chk("reset cs1", {112'b0, cs1}, 0);
        chk("reset busy", {busy[0], busy[1]}, 0);
        chk("reset acks", {a_ack[0], b_ack[0], a_ack[1], b_ack[1]}, 0);
        chk("reset rdata", {a_rdata[0], b_rdata[0], a_rdata[1], b_rdata[1]}, 0);
        chk("reset wdata", {regdata_write[0], regdata_write[1], we[0], we[1]}, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 13; k++) do_txn(k, vecs[k]);
        chk("d1 oor write left regs", mem1[4], 8'h04 ^ 8'h3F);

        // Reset mid-access aborts the write with no ack
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 1'b1, 7'h05, 8'hEE);
        @(posedge clk); #1;
        chk("rst pre cs5", cs0[5], 1);
        rst_n = 1'b0;
        #1;
        chk("rst cs", cs0, 0);
        chk("rst we", we[0], 0);
        chk("rst ack", a_ack[0], 0);
        chk("rst busy", busy[0], 0);
        chk("rst rdata", a_rdata[0], 0);
        drive(0, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ack_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_ack[0] || b_ack[0]) ack_seen++;
        end
        chk("rst no ack", ack_seen, 0);
        chk("rst no write", mem0[5], 8'h5A);

        // Continuous contention from reset: A, B, A, B, three cycles apart
        @(posedge clk); #1;
        a_wr[0] = 1'b0; a_addr[0] = 7'h05;
        b_wr[0] = 1'b0; b_addr[0] = 7'h12;
        n_ack = 0;
        exp_q.push_back({1'b0, 7'd2});
        exp_q.push_back({1'b1, 7'd5});
        exp_q.push_back({1'b0, 7'd8});
        exp_q.push_back({1'b1, 7'd11});
        for (int c = 0; c < 16; c++) begin
            a_req[0] = (n_ack < 4);
            b_req[0] = (n_ack < 4);
            @(negedge clk);
            if (a_ack[0]) note_ack("cont", 1'b0, c, 8'h5A);
            if (b_ack[0]) note_ack("cont", 1'b1, c, 8'hA5);
            @(posedge clk); #1;
        end
        chk("cont leftover", exp_q.size(), 0);
        chk("cont count", n_ack, 4);

        // A holds req one cycle past ack; B arrives during the repeat access
        a_wr[0] = 1'b0; a_addr[0] = 7'h00;
        b_wr[0] = 1'b0; b_addr[0] = 7'h7F;
        n_ack = 0;
        exp_q.push_back({1'b0, 7'd2});
        exp_q.push_back({1'b0, 7'd5});
        exp_q.push_back({1'b1, 7'd8});
        for (int c = 0; c < 13; c++) begin
            a_req[0] = (c <= 3);
            b_req[0] = (c >= 4 && c <= 8);
            @(negedge clk);
            if (a_ack[0]) note_ack("held", 1'b0, c, 8'h55);
            if (b_ack[0]) note_ack("held", 1'b1, c, 8'hC3);
            @(posedge clk); #1;
        end
        chk("held leftover", exp_q.size(), 0);
        chk("held count", n_ack, 3);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbus_arbiter.md
# regbus_arbiter

Two-port arbiter and sequencer for the shared 8-bit internal register bus (one-hot `cs`, `we`, `regdata_write`, `regdata_read`). Port A is the SPI host register bridge; port B is the on-chip Maple transfer sequencer. The block serialises their accesses with round-robin fairness. It drives single-beat read/write cycles with configurable wait states and reports out-of-range addresses.

## Interface

Parameters:
- `num_regs`, 128 — number of register selects; valid addresses are 0..`num_regs`-1 (max 128).
- `wait_cycles`, 0 — extra cycles `cs` is held per access (0..15).

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `a_req` in 1 — port A request, level; held until `a_ack`.
- `a_wr` in 1 — 1 = write, 0 = read; stable while `a_req`.
- `a_addr` in 7 — register number; stable while `a_req`.
- `a_wdata` in 8 — write data; stable while `a_req`.
- `a_rdata` out 8 — read data, valid in `a_ack` cycle and held until next A completion.
- `a_ack` out 1 — one-cycle completion pulse.
- `a_err` out 1 — high with `a_ack` if address was out of range.
- `b_req`, `b_wr`, `b_addr`, `b_wdata`, `b_rdata`, `b_ack`, `b_err` — identical set for port B.
- `cs` out `num_regs` — one-hot register select.
- `we` out 1 — write strobe, qualifies `cs`.
- `regdata_write` out 8 — write data to registers, driven (never tri-stated).
- `regdata_read` in 8 — read data from selected register, combinational from `cs`.
- `busy` out 1 — high in any state other than IDLE.

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No requests: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the port not granted last.
  - `last_grant` resets to B, so A wins the first tie.
  - On grant, latch port id, `wr`, `addr`, `wdata`; load the wait counter with `wait_cycles`; go to ACCESS; update `last_grant`.
- ACCESS:
  - `cs[addr]` = 1, `we` = latched `wr`, `regdata_write` = latched `wdata`.
  - Wait counter decrements each cycle; at 0, capture `regdata_read` into the granted port's `rdata` (reads only) and go to DONE.
- DONE:
  - `cs` = 0, `we` = 0.
  - Granted port's `ack` = 1 and `err` = range flag.
  - Go to IDLE unconditionally.
- Out-of-range (`addr` >= `num_regs`):
  - Full ACCESS/DONE timing is kept.
  - `cs` stays all-zero and `we` stays 0, so no write occurs.
  - Reads return 8'hFF.
  - `err` = 1 with `ack`.
- The non-granted port's request is held pending and unaffected. `rdata` of the non-granted port is never modified.
- A write never updates any `rdata`.
- `regdata_write` = 0 and `we` = 0 outside ACCESS.

## Timing

- Reset (async assert, any state):
  - FSM goes to IDLE.
  - `cs`, `we`, `regdata_write`, `a_rdata`, `b_rdata`, `a_ack`, `b_ack`, `a_err`, `b_err`, `busy` all 0.
  - `last_grant` = B.
  - An in-flight transaction is aborted with no `ack`.
  - Deassertion is used as-is; the surrounding design synchronises it to `clk`.
- Latency, request high in cycle 0 while IDLE:
  - ACCESS in cycles 1..1+`wait_cycles`.
  - `ack` in cycle 2+`wait_cycles`.
  - Next grant possible in cycle 3+`wait_cycles`.
- Throughput: one access per `wait_cycles`+3 cycles.
- Handshake:
  - The requester drops `req` on the edge that samples `ack` = 1.
  - `req` still high in the cycle after `ack` is a new request.
  - Changing `addr`/`wr`/`wdata` mid-request is illegal. Fields are latched at grant, so later changes have no effect on the current access.
- Simultaneous: a new request arriving during ACCESS/DONE of the other port is served at the next IDLE. Alternation is strict under continuous contention.
- `busy` is 1 from cycle 1 through the DONE cycle.

## Test plan

- Reset: hold `rst_n` = 0 for 3 cycles mid-ACCESS (`cs[5]` high) -> `cs`, `we`, `ack` drop to 0 immediately; no `ack` ever issued for that access.
- A write with `wait_cycles` = 0, `a_addr` = 7'h12, `a_wdata` = 8'hA5:
  - Req in cycle 0 -> `cs[18]` = 1, `we` = 1, `regdata_write` = A5 in cycle 1 only.
  - `a_ack` = 1 and `a_err` = 0 in cycle 2.
- B read with `wait_cycles` = 2, `b_addr` = 3, model returns 8'h3C:
  - `cs[3]` high for cycles 1–3.
  - `b_ack` in cycle 4 with `b_rdata` = 3C; `a_rdata` unchanged.
- Contention: `a_req` and `b_req` both high continuously for 4 transactions from reset -> grant order A, B, A, B; acks 3 cycles apart (`wait_cycles` = 0).
- Out-of-range with `num_regs` = 16, `a_addr` = 20:
  - Read -> `cs` all 0; `a_ack` with `a_err` = 1 and `a_rdata` = FF.
  - Write -> `we` = 0 throughout; `a_err` = 1.
- Held `req` after `ack`: A keeps `a_req` high one extra cycle -> a second access is performed and acked; B pending meanwhile is served only after it.
